// File: rtl/seven_seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with a double-buffered load port.
// The display buffer is swapped only when the scan wraps from digit 7 to digit 0.
module seven_seg_scan_ctrl #(
   parameter int DIV_BITS    = 3,
   parameter int BLANK_TICKS = 1
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic [31:0] Data,
   input  logic [7:0]  DigitEn,
   input  logic [7:0]  DpIn,
   input  logic        LoadReq,
   output logic        LoadAck,
   output logic [7:0]  SevenSegAn,
   output logic [6:0]  SevenSegCat,
   output logic        SevenSegDp,
   output logic [2:0]  DigitIdx
);

   localparam int CW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS + 1) : 1;

   typedef enum logic {SHOW, BLANK} state_t;

   state_t              state, state_n;
   logic [DIV_BITS-1:0] pre;
   logic                tick;
   logic [CW-1:0]       bcnt, bcnt_n;
   logic [2:0]          idx_n;
   logic                wrap, transfer, capture;

   logic [31:0] pend_data, act_data, act_data_n;
   logic [7:0]  pend_en, pend_dp, act_en, act_en_n, act_dp, act_dp_n;
   logic        pend_full;

   logic [7:0]  an_n;
   logic [6:0]  cat_n;
   logic        dp_n;

   function automatic logic [6:0] hex_seg(input logic [3:0] v);
      case (v)
         4'h0: hex_seg = 7'h40;
         4'h1: hex_seg = 7'h79;
         4'h2: hex_seg = 7'h24;
         4'h3: hex_seg = 7'h30;
         4'h4: hex_seg = 7'h19;
         4'h5: hex_seg = 7'h12;
         4'h6: hex_seg = 7'h02;
         4'h7: hex_seg = 7'h78;
         4'h8: hex_seg = 7'h00;
         4'h9: hex_seg = 7'h10;
         4'hA: hex_seg = 7'h08;
         4'hB: hex_seg = 7'h03;
         4'hC: hex_seg = 7'h46;
         4'hD: hex_seg = 7'h21;
         4'hE: hex_seg = 7'h06;
         default: hex_seg = 7'h0E;
      endcase
   endfunction

   assign tick = &pre;

   always_comb begin
      state_n = state;
      idx_n   = DigitIdx;
      bcnt_n  = bcnt;
      if (tick) begin
         case (state)
            SHOW: begin
               if (BLANK_TICKS > 0) begin
                  state_n = BLANK;
                  bcnt_n  = CW'(BLANK_TICKS);
               end else begin
                  idx_n = DigitIdx + 3'd1;
               end
            end
            default: begin
               // A zero count (only possible straight out of reset) ends after one tick.
               if (bcnt > CW'(1)) begin
                  bcnt_n = bcnt - CW'(1);
               end else begin
                  state_n = SHOW;
                  idx_n   = DigitIdx + 3'd1;
               end
            end
         endcase
      end
   end

   always_comb begin
      wrap       = (DigitIdx == 3'd7) && (idx_n == 3'd0);
      transfer   = wrap && pend_full;
      act_data_n = transfer ? pend_data : act_data;
      act_en_n   = transfer ? pend_en   : act_en;
      act_dp_n   = transfer ? pend_dp   : act_dp;
      // The ack cycle still sees LoadReq high; it must not be taken as a fresh request.
      capture    = LoadReq && !LoadAck && (!pend_full || transfer);
   end

   // Outputs are derived from next-state values so they line up with the registered state.
   always_comb begin
      an_n  = 8'hFF;
      cat_n = 7'h7F;
      dp_n  = 1'b1;
      if (state_n == SHOW) begin
         an_n  = act_en_n[idx_n] ? ~(8'h01 << idx_n) : 8'hFF;
         cat_n = hex_seg(act_data_n[{idx_n, 2'b00} +: 4]);
         dp_n  = ~act_dp_n[idx_n];
      end
   end

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         pre         <= '0;
         state       <= BLANK;
         bcnt        <= CW'(BLANK_TICKS);
         DigitIdx    <= 3'd7;
         pend_data   <= '0;
         pend_en     <= '0;
         pend_dp     <= '0;
         pend_full   <= 1'b0;
         act_data    <= '0;
         act_en      <= '0;
         act_dp      <= '0;
         LoadAck     <= 1'b0;
         SevenSegAn  <= '1;
         SevenSegCat <= '1;
         SevenSegDp  <= 1'b1;
      end else begin
         pre         <= pre + DIV_BITS'(1);
         state       <= state_n;
         bcnt        <= bcnt_n;
         DigitIdx    <= idx_n;
         act_data    <= act_data_n;
         act_en      <= act_en_n;
         act_dp      <= act_dp_n;
         pend_full   <= capture || (pend_full && !transfer);
         LoadAck     <= capture;
         SevenSegAn  <= an_n;
         SevenSegCat <= cat_n;
         SevenSegDp  <= dp_n;
         if (capture) begin
            pend_data <= Data;
            pend_en   <= DigitEn;
            pend_dp   <= DpIn;
         end
      end
   end

endmodule
